// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - handshaked load/store unit: lane alignment, byte enables, bus access, WB formatting
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_rvalid,
  input  logic [XLEN-1:0]     bus_rdata,
  input  logic                bus_err,
  output logic                rsp_valid,
  output logic                rsp_load,
  output logic [4:0]          rsp_rd,
  output logic [XLEN-1:0]     rsp_data,
  output logic [1:0]          rsp_exc_code,
  output logic                busy
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);

  typedef enum logic [1:0] {IDLE, BUS_REQ, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;

  logic       legal, misal;
  logic [1:0] req_exc;
  logic       timeout_hit;

  // Illegal funct3 takes precedence over misalignment.
  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b011:                 legal = (XLEN == 64);
      3'b100, 3'b101:         legal = !req_we;
      3'b110:                 legal = !req_we && (XLEN == 64);
      default:                legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'd1:    misal = req_addr[0];
      2'd2:    misal = |req_addr[1:0];
      2'd3:    misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
    req_exc = !legal ? 2'd3 : (misal ? 2'd1 : 2'd0);
  end

  logic [OFFW-1:0] off;
  logic [BEW-1:0]  size_mask;
  assign off = addr_q[OFFW-1:0];

  always_comb begin
    size_mask = '0;
    case (f3_q[1:0])
      2'd0:    size_mask = BEW'(1);
      2'd1:    size_mask = BEW'(3);
      2'd2:    size_mask = BEW'(15);
      default: size_mask = '1;
    endcase
  end

  // Signed views let a size cast perform the sign extension for any XLEN.
  logic [XLEN-1:0]    shifted, load_fmt;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] w_s;

  always_comb begin
    shifted  = bus_rdata >> {off, 3'b000};
    b_s      = shifted[7:0];
    h_s      = shifted[15:0];
    w_s      = shifted[31:0];
    load_fmt = shifted;
    case (f3_q)
      3'b000:  load_fmt = XLEN'(b_s);
      3'b001:  load_fmt = XLEN'(h_s);
      3'b010:  load_fmt = XLEN'(w_s);
      3'b100:  load_fmt = XLEN'(shifted[7:0]);
      3'b101:  load_fmt = XLEN'(shifted[15:0]);
      3'b110:  load_fmt = XLEN'(shifted[31:0]);
      default: load_fmt = shifted;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                to_cnt <= '0;
    else if (state == BUS_REQ || state == WAIT) to_cnt <= to_cnt + 16'd1;
    else                                       to_cnt <= '0;
  end

  assign timeout_hit = (state == BUS_REQ || state == WAIT) && (to_cnt == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^(16'(TIMEOUT));
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (req_exc == 2'd0) ? BUS_REQ : RESP;
      BUS_REQ: begin
        if (bus_ready)        state_nxt = WAIT;
        else if (timeout_hit) state_nxt = RESP;
      end
      WAIT:    if (bus_rvalid || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign bus_valid = (state == BUS_REQ);
  assign bus_we    = bus_valid && we_q;
  assign bus_addr  = bus_valid ? {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
  assign bus_be    = !bus_valid ? '0 : (we_q ? (size_mask << off) : '1);
  assign bus_wdata = bus_we ? (wdata_q << {off, 3'b000}) : '0;

  // rsp_* are loaded only on entry to RESP so they hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      rsp_load     <= 1'b0;
      rsp_rd       <= '0;
      rsp_data     <= '0;
      rsp_exc_code <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rd_q    <= req_rd;
          if (req_exc != 2'd0) begin
            rsp_load     <= !req_we;
            rsp_rd       <= req_rd;
            rsp_data     <= '0;
            rsp_exc_code <= req_exc;
          end
        end
        BUS_REQ: if (!bus_ready && timeout_hit) begin
          rsp_load     <= !we_q;
          rsp_rd       <= rd_q;
          rsp_data     <= '0;
          rsp_exc_code <= 2'd2;
        end
        WAIT: if (bus_rvalid || timeout_hit) begin
          rsp_load     <= !we_q;
          rsp_rd       <= rd_q;
          rsp_data     <= (!bus_rvalid || bus_err || we_q) ? '0 : load_fmt;
          rsp_exc_code <= (!bus_rvalid || bus_err) ? 2'd2 : 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
